// File: rtl/insn_stream_loader.sv
// Byte-stream program loader: parses MAGIC / N(16b LE) / N words LE / XOR checksum,
// writes each word into instruction memory and holds the core in reset until verified.
module insn_stream_loader #(
    parameter int         ADDR_WIDTH = 10,
    parameter logic [7:0] MAGIC      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    // Largest legal word count; one bit wider than the 16-bit length field.
    localparam logic [16:0] LIMIT = 17'(1 << ADDR_WIDTH);

    state_t                state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   addr_q, addr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [23:0]           asm_q, asm_d;
    logic [7:0]            csum_q, csum_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic                  xfer;
    logic [15:0]           n_words;
    logic [ADDR_WIDTH:0]   addr_nxt;

    // The write cycle doubles as the per-word stall.
    assign rx_ready  = !we_q;
    assign xfer      = rx_valid && rx_ready;
    assign n_words   = {rx_data, len_lo_q};
    assign addr_nxt  = addr_q + 1'b1;

    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign core_hold = (state_q != DONE);
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERROR);
    assign busy      = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == DATA)   || (state_q == CHECK);

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        csum_d   = csum_q;
        we_d     = 1'b0;
        maddr_d  = maddr_q;
        wdata_d  = wdata_q;

        if (xfer) begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (rx_data == MAGIC) begin
                        state_d = LEN_LO;
                        csum_d  = '0;
                        cnt_d   = '0;
                        addr_d  = '0;
                    end
                end
                LEN_LO: begin
                    len_lo_d = rx_data;
                    state_d  = LEN_HI;
                end
                LEN_HI: begin
                    len_d = n_words[ADDR_WIDTH:0];
                    if ({1'b0, n_words} > LIMIT)
                        state_d = ERROR;
                    else if (n_words == 16'd0)
                        state_d = CHECK;
                    else
                        state_d = DATA;
                end
                DATA: begin
                    csum_d = csum_q ^ rx_data;
                    cnt_d  = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: begin
                            we_d    = 1'b1;
                            maddr_d = addr_q[ADDR_WIDTH-1:0];
                            wdata_d = {rx_data, asm_q};
                            addr_d  = addr_nxt;
                            if (addr_nxt == len_q)
                                state_d = CHECK;
                        end
                    endcase
                end
                CHECK: begin
                    state_d = (rx_data == csum_q) ? DONE : ERROR;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            asm_q    <= '0;
            csum_q   <= '0;
            we_q     <= 1'b0;
            maddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            csum_q   <= csum_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_insn_stream_loader.sv
// Directed bench for insn_stream_loader: framing, checksum, length limits,
// mid-image reset and a full-depth image.
module tb_insn_stream_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold, busy, done, error;

    int total = 0;
    int bad   = 0;

    insn_stream_loader #(.ADDR_WIDTH(10), .MAGIC(8'hA5)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_hold(core_hold), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Write log; also flags writes that are not single-cycle or that leave rx_ready high.
    logic [9:0]  waddr[$];
    logic [31:0] wdat[$];
    int          viol = 0;
    logic        prev_we = 1'b0;
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            waddr.push_back(mem_addr);
            wdat.push_back(mem_wdata);
            if (rx_ready !== 1'b0) viol++;
            if (prev_we === 1'b1) viol++;
        end
        prev_we = mem_we;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_log();
        waddr.delete();
        wdat.delete();
    endtask

    task automatic send_img2(input logic [7:0] last);
        logic [7:0] img[12];
        img = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h80, 8'h20, 8'h03,
                8'h13, 8'h01, 8'h40, 8'h01, 8'h63};
        img[11] = last;
        for (int i = 0; i < 12; i++) send(img[i]);
        idle(2);
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  cs;
        int          errs, zeros;

        // Reset with a MAGIC byte offered: it must not be taken.
        @(negedge clk);
        reset = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
        repeat (2) @(negedge clk);
        chk("rst_core_hold", {31'd0, core_hold}, 32'd1);
        chk("rst_rx_ready",  {31'd0, rx_ready},  32'd1);
        chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rst_mem_addr",  {22'd0, mem_addr},  32'd0);
        chk("rst_mem_wdata", mem_wdata,          32'd0);
        chk("rst_flags",     {29'd0, busy, done, error}, 32'd0);
        reset = 1'b0; rx_valid = 1'b0;
        idle(1);
        chk("post_rst_idle", {28'd0, busy, done, error, core_hold}, 32'd1);

        // Normal 2-word image.
        clr_log();
        send_img2(8'h63);
        chk("norm_nwr", waddr.size(), 32'd2);
        if (waddr.size() == 2) begin
            chk("norm_a0", {22'd0, waddr[0]}, 32'd0);
            chk("norm_d0", wdat[0], 32'h03208093);
            chk("norm_a1", {22'd0, waddr[1]}, 32'd1);
            chk("norm_d1", wdat[1], 32'h01400113);
        end
        chk("norm_done",  {29'd0, done, error, core_hold}, 32'b100);
        chk("norm_hold_addr",  {22'd0, mem_addr}, 32'd1);
        chk("norm_hold_wdata", mem_wdata, 32'h01400113);

        // Bad checksum, then a good image must recover.
        clr_log();
        send_img2(8'h64);
        chk("badcs_nwr", waddr.size(), 32'd2);
        chk("badcs_flags", {29'd0, done, error, core_hold}, 32'b011);
        send(8'hA5);
        chk("restart_clears", {28'd0, busy, done, error, core_hold}, 32'b1001);
        send(8'h02); send(8'h00);
        for (int i = 0; i < 4; i++) send(8'h11 * 8'(i + 1));
        for (int i = 0; i < 4; i++) send(8'h22);
        send(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
        idle(2);
        chk("recover_flags", {29'd0, done, error, core_hold}, 32'b100);
        if (wdat.size() == 4) chk("recover_d0", wdat[2], 32'h44332211);

        // Empty image.
        clr_log();
        send(8'hA5); send(8'h00); send(8'h00);
        chk("empty_busy", {31'd0, busy}, 32'd1);
        send(8'h00);
        idle(2);
        chk("empty_nwr", waddr.size(), 32'd0);
        chk("empty_done", {29'd0, done, error, core_hold}, 32'b100);

        // Oversize image (N=1025): error right after the length bytes.
        send(8'hA5); send(8'h01); send(8'h04);
        chk("over_flags", {28'd0, busy, done, error, core_hold}, 32'b0011);
        idle(2);
        chk("over_nwr", waddr.size(), 32'd0);

        // Noise, gaps, then reset in the middle of the second word.
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        clr_log();
        send(8'h00); idle(1); send(8'hFF);
        chk("noise_ignored", {31'd0, busy}, 32'd1 - 32'd1 + {31'd0, 1'b0});
        send(8'hA5); idle(2); send(8'h02); send(8'h00); idle(1);
        send(8'h93); idle(3); send(8'h80); send(8'h20); idle(1); send(8'h03);
        send(8'h13); idle(2); send(8'h01);
        rx_data = 8'h40; rx_valid = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("midrst_flags", {28'd0, busy, done, error, core_hold}, 32'b0001);
        chk("midrst_we_addr", {21'd0, mem_we, mem_addr}, 32'd0);
        chk("midrst_wdata", mem_wdata, 32'd0);
        reset = 1'b0; rx_valid = 1'b0;
        idle(3);
        chk("midrst_nwr", waddr.size(), 32'd1);
        if (waddr.size() == 1) chk("midrst_d0", wdat[0], 32'h03208093);

        // Full-depth image: 1024 words, last at 1023, no wrap.
        clr_log();
        cs = 8'h00;
        send(8'hA5); send(8'h00); send(8'h04);
        for (int i = 0; i < 1024; i++) begin
            w = (32'(i) * 32'h9E3779B1) ^ 32'h00000013;
            for (int k = 0; k < 4; k++) begin
                send(w[k*8 +: 8]);
                cs = cs ^ w[k*8 +: 8];
            end
        end
        chk("full_busy_check", {29'd0, busy, done, error}, 32'b100);
        send(cs);
        idle(2);
        chk("full_nwr", waddr.size(), 32'd1024);
        errs = 0; zeros = 0;
        for (int i = 0; i < waddr.size(); i++) begin
            w = (32'(i) * 32'h9E3779B1) ^ 32'h00000013;
            if (waddr[i] !== 10'(i) || wdat[i] !== w) errs++;
            if (waddr[i] === 10'd0) zeros++;
        end
        chk("full_seq", errs, 32'd0);
        chk("full_no_wrap", zeros, 32'd1);
        chk("full_last_addr", {22'd0, mem_addr}, 32'd1023);
        chk("full_done", {29'd0, done, error, core_hold}, 32'b100);

        chk("write_pulse_stall", viol, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
